data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- MEM-stage data cache controller. It consumes the EXE/MEM pipeline register outputs (address, store data, control) and returns load data to the MEM/WB path.
- It drives the global pipeline freeze while an external memory transaction is outstanding.
- Organisation: direct-mapped, one 32-bit word per line, write-through, no-write-allocate. Supports word and byte (LB/SB) accesses.

Parameters:
INDEX_BITS, 6, line index width; the cache holds 2^INDEX_BITS lines.
TAG_BITS, 30-INDEX_BITS, tag width (derived, not overridable).

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
cache_en  in  1  memory access valid this cycle
mem_write  in  1  1 = store, 0 = load (meaningful only when cache_en=1)
is_LB_SB  in  1  byte access when 1, word access when 0
alu_result  in  32  effective byte address
rt_data  in  32  store data
read_data  out  32  load result (combinational)
freeze  out  1  stall request to all pipeline registers (combinational)
mem_req  out  1  memory request (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  32  word-aligned address {alu_result[31:2],2'b00} (registered)
mem_be  out  4  byte enables (registered)
mem_wdata  out  32  memory write data (registered)
mem_rdata  in  32  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completes the request at this clk edge

Behaviour:
- Reset is asynchronous, active-low, on rst_b; clock is clk.
- Reset values:
  - state=IDLE; all valid bits=0.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata all 0; resp_reg=0.
  - freeze forced 0 and read_data forced 0 while rst_b=0.
- Address split: index=alu_result[INDEX_BITS+1:2]; tag=alu_result[31:INDEX_BITS+2]. hit = valid[index] & (tag_arr[index]==tag).
- load = cache_en & ~mem_write; store = cache_en & mem_write.
- Byte lanes are little-endian: lane k = bits 8k+7:8k, selected by alu_result[1:0].
  - Word accesses ignore alu_result[1:0].
  - LB result is the selected byte, sign-extended to 32 bits.
  - SB: mem_be=1<<alu_result[1:0], mem_wdata={4{rt_data[7:0]}}.
  - SW: mem_be=4'b1111, mem_wdata=rt_data.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE:
  - cache_en=0: freeze=0, read_data=0, no state change.
  - Load hit: freeze=0; read_data comes from the array the same cycle (0 extra latency).
  - Load miss: freeze=1. At the edge, register mem_req=1, mem_we=0, mem_be=4'b1111, mem_addr; go to RD_WAIT.
  - Store (hit or miss): freeze=1. At the edge, register mem_req=1, mem_we=1, mem_be, mem_wdata, mem_addr; go to WR_WAIT.
  - Store hit: at that same edge, update only the enabled byte lanes of the line. Tag and valid are unchanged.
  - Store miss: the array is untouched (no allocate).
- RD_WAIT:
  - freeze=1.
  - At an edge with mem_ready=1: mem_req<=0; line[index]<=mem_rdata with tag set and valid=1; resp_reg<=mem_rdata; go to RESP.
- WR_WAIT:
  - freeze=1.
  - At an edge with mem_ready=1: mem_req<=0, mem_we<=0; go to RESP.
- RESP:
  - freeze=0.
  - read_data is extracted from resp_reg (word or sign-extended byte) for loads; 0 for stores.
  - Next state is IDLE. The pipeline register advances at this edge.
- Outputs remain stable while mem_req=1; mem_req never drops before mem_ready is sampled high.
- Minimum load-miss timing: 2 frozen cycles plus the RESP cycle, when mem_ready=1 in the first RD_WAIT cycle.
- Inputs are held stable by the upstream freeze from IDLE through RESP. The block does not re-sample them after leaving IDLE, except the index/tag/lane select used for fill and extract.
- mem_ready while in IDLE or RESP is ignored.
- Reset mid-transaction: mem_req drops asynchronously, the in-flight request is abandoned, and the cache is invalidated.

Decomposition:
- Shared package mips_pkg holds:
  - the cache state enum;
  - the byte-lane/byte-enable helper constants;
  - a function be_from_addr(addr[1:0], is_byte);
  - the LB sign-extend extraction function.
- One sub-module, cache_array: tag/valid/data storage, asynchronous read, synchronous byte-enabled write, asynchronous valid clear on rst_b.

Test Plan:
- Reset, then LW 0x0000_0040 with mem_rdata=0xDEADBEEF and mem_ready on the 2nd RD_WAIT cycle:
  - freeze is high for 3 cycles; read_data=0xDEADBEEF in RESP.
  - Repeating LW 0x40 hits: freeze=0, same-cycle data.
- After the fill above, SB 0x43 with rt_data=0x000000AA (hit):
  - mem_be=4'b1000, mem_wdata=0xAAAAAAAA.
  - A following LW 0x40 hits with 0xAAADBEEF; LB 0x43 returns 0xFFFFFFAA.
- SW 0x0000_1000, data 0x12345678, to an uncached line:
  - freeze is held until mem_ready; mem_we=1.
  - A following LW 0x1000 misses (no allocate) and issues mem_req.
- Conflict: LW 0x40, then LW 0x140 (INDEX_BITS=6, same index, different tag):
  - the second access misses and refills;
  - LW 0x40 then misses again.
- Assert rst_b=0 in RD_WAIT with mem_ready=0:
  - mem_req=0 and freeze=0 immediately;
  - after release, LW 0x40 misses (valid cleared).
- cache_en=0 with arbitrary alu_result: freeze=0, mem_req stays 0, read_data=0 for 10 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared cache state enum, byte-lane constants and load/store lane helpers
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } cache_state_t;

  localparam int          LANES    = 4;
  localparam logic [3:0]  BE_WORD  = 4'b1111;
  localparam logic [3:0]  BE_BYTE0 = 4'b0001;

  function automatic logic [3:0] be_from_addr(input logic [1:0] addr, input logic is_byte);
    return is_byte ? (BE_BYTE0 << addr) : BE_WORD;
  endfunction

  // Little-endian lane select, then sign-extend the byte to a full word.
  function automatic logic [31:0] lb_extract(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return {{24{shifted[7]}}, shifted[7:0]};
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic is_byte);
    return is_byte ? lb_extract(word, lane) : word;
  endfunction

endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - tag/valid/data storage: async read, byte-enabled sync write, async valid clear
module cache_array
  import mips_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] index,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data,
  input  logic                  fill,
  input  logic [TAG_BITS-1:0]   fill_tag
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [31:0]         data_arr [LINES];

  assign rd_tag   = tag_arr[index];
  assign rd_valid = valid[index];
  assign rd_data  = data_arr[index];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid <= '0;
    end else if (fill) begin
      valid[index] <= 1'b1;
    end
  end

  // Payload storage needs no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_be[k]) data_arr[index][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
    if (fill) tag_arr[index] <= fill_tag;
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - MEM-stage direct-mapped write-through no-allocate data cache with pipeline freeze
module data_cache
  import mips_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cache_en,
  input  logic        mem_write,
  input  logic        is_LB_SB,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_data,
  output logic [31:0] read_data,
  output logic        freeze,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  cache_state_t state, next_state;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag, line_tag;
  logic [31:0]           line_data, resp_reg, store_wdata;
  logic [3:0]            store_be;
  logic                  line_valid, hit, load, store;
  logic                  issue_rd, issue_wr, hit_write, fill;

  assign index       = alu_result[INDEX_BITS+1:2];
  assign tag         = alu_result[31:INDEX_BITS+2];
  assign load        = cache_en & ~mem_write;
  assign store       = cache_en & mem_write;
  assign hit         = line_valid & (line_tag == tag);
  assign store_be    = be_from_addr(alu_result[1:0], is_LB_SB);
  assign store_wdata = is_LB_SB ? {4{rt_data[7:0]}} : rt_data;

  cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst_b    (rst_b),
    .index    (index),
    .rd_tag   (line_tag),
    .rd_valid (line_valid),
    .rd_data  (line_data),
    .wr_en    (fill | hit_write),
    .wr_be    (fill ? BE_WORD : store_be),
    .wr_data  (fill ? mem_rdata : store_wdata),
    .fill     (fill),
    .fill_tag (tag)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    freeze     = 1'b0;
    read_data  = '0;
    issue_rd   = 1'b0;
    issue_wr   = 1'b0;
    hit_write  = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (hit) begin
            read_data = load_extract(line_data, alu_result[1:0], is_LB_SB);
          end else begin
            freeze     = 1'b1;
            issue_rd   = 1'b1;
            next_state = RD_WAIT;
          end
        end else if (store) begin
          freeze     = 1'b1;
          issue_wr   = 1'b1;
          hit_write  = hit;
          next_state = WR_WAIT;
        end
      end
      RD_WAIT: begin
        freeze = 1'b1;
        if (mem_ready) begin
          fill       = 1'b1;
          next_state = RESP;
        end
      end
      WR_WAIT: begin
        freeze = 1'b1;
        if (mem_ready) next_state = RESP;
      end
      RESP: begin
        if (load) read_data = load_extract(resp_reg, alu_result[1:0], is_LB_SB);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (!rst_b) begin
      freeze    = 1'b0;
      read_data = '0;
    end
  end

  // Memory-side outputs are held from issue until mem_ready is seen in a wait state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      resp_reg  <= '0;
    end else begin
      if (issue_rd) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_be   <= BE_WORD;
        mem_addr <= {alu_result[31:2], 2'b00};
      end
      if (issue_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_be    <= store_be;
        mem_wdata <= store_wdata;
        mem_addr  <= {alu_result[31:2], 2'b00};
      end
      if ((state == RD_WAIT || state == WR_WAIT) && mem_ready) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (fill) resp_reg <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cache_en, mem_write, is_LB_SB;
  logic [31:0] alu_result, rt_data, read_data, mem_addr, mem_wdata, mem_rdata;
  logic        freeze, mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;
  int frz;
  logic        s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;

  data_cache #(.INDEX_BITS(6)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cache_en   (cache_en),
    .mem_write  (mem_write),
    .is_LB_SB   (is_LB_SB),
    .alu_result (alu_result),
    .rt_data    (rt_data),
    .read_data  (read_data),
    .freeze     (freeze),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic we, input logic bsel, input logic [31:0] a, input logic [31:0] d);
    cache_en = 1'b1; mem_write = we; is_LB_SB = bsel; alu_result = a; rt_data = d;
    #1;
  endtask

  // Runs a frozen access from its IDLE cycle to RESP, raising mem_ready in wait cycle r.
  // Returns the number of frozen cycles and snapshots the request in the first wait cycle.
  task automatic serve(input int r, input logic [31:0] rdata, output int n);
    n = 0;
    mem_rdata = rdata;
    while (freeze === 1'b1 && n < 50) begin
      n++;
      if (n == 2) begin
        s_req = mem_req; s_we = mem_we; s_be = mem_be; s_addr = mem_addr; s_wdata = mem_wdata;
      end
      mem_ready = (n == r + 1);
      step();
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; cache_en = 1'b0; mem_write = 1'b0; is_LB_SB = 1'b0;
    alu_result = 32'h0; rt_data = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    step(); step();
    chk("rst_freeze", {31'b0, freeze}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_b = 1'b1;
    step();

    // Cold load miss, mem_ready on the 2nd RD_WAIT cycle
    set_acc(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    chk("lw_miss_freeze_idle", {31'b0, freeze}, 32'd1);
    serve(2, 32'hDEAD_BEEF, frz);
    chk("lw_miss_frozen_cycles", frz, 32'd3);
    chk("lw_miss_req", {31'b0, s_req}, 32'd1);
    chk("lw_miss_we", {31'b0, s_we}, 32'd0);
    chk("lw_miss_be", {28'b0, s_be}, 32'hF);
    chk("lw_miss_addr", s_addr, 32'h40);
    chk("lw_resp_data", read_data, 32'hDEAD_BEEF);
    chk("lw_resp_freeze", {31'b0, freeze}, 32'd0);
    chk("lw_resp_req_low", {31'b0, mem_req}, 32'd0);
    step();
    chk("lw_hit_freeze", {31'b0, freeze}, 32'd0);
    chk("lw_hit_data", read_data, 32'hDEAD_BEEF);
    step();
    chk("lw_hit_no_req", {31'b0, mem_req}, 32'd0);

    // Byte store hit to lane 3
    set_acc(1'b1, 1'b1, 32'h0000_0043, 32'h0000_00AA);
    serve(1, 32'h0, frz);
    chk("sb_frozen_cycles", frz, 32'd2);
    chk("sb_we", {31'b0, s_we}, 32'd1);
    chk("sb_be", {28'b0, s_be}, 32'h8);
    chk("sb_wdata", s_wdata, 32'hAAAA_AAAA);
    chk("sb_addr", s_addr, 32'h40);
    chk("sb_resp_data", read_data, 32'h0);
    step();
    set_acc(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    chk("lw_after_sb_freeze", {31'b0, freeze}, 32'd0);
    chk("lw_after_sb_data", read_data, 32'hAAAD_BEEF);
    set_acc(1'b0, 1'b1, 32'h0000_0043, 32'h0);
    chk("lb_43", read_data, 32'hFFFF_FFAA);
    set_acc(1'b0, 1'b1, 32'h0000_0041, 32'h0);
    chk("lb_41", read_data, 32'hFFFF_FFBE);
    set_acc(1'b0, 1'b1, 32'h0000_0040, 32'h0);
    chk("lb_40", read_data, 32'hFFFF_FFEF);

    // Word store miss: no allocate
    set_acc(1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678);
    serve(3, 32'h0, frz);
    chk("sw_frozen_cycles", frz, 32'd4);
    chk("sw_we", {31'b0, s_we}, 32'd1);
    chk("sw_be", {28'b0, s_be}, 32'hF);
    chk("sw_wdata", s_wdata, 32'h1234_5678);
    chk("sw_addr", s_addr, 32'h1000);
    step();
    set_acc(1'b0, 1'b0, 32'h0000_1000, 32'h0);
    chk("lw_1000_miss", {31'b0, freeze}, 32'd1);
    serve(1, 32'h1234_5678, frz);
    chk("lw_1000_req", {31'b0, s_req}, 32'd1);
    chk("lw_1000_frozen", frz, 32'd2);
    chk("lw_1000_resp", read_data, 32'h1234_5678);
    step();
    set_acc(1'b0, 1'b1, 32'h0000_1000, 32'h0);
    chk("lb_1000_positive", read_data, 32'h0000_0078);

    // Conflict on index 0x10
    set_acc(1'b0, 1'b0, 32'h0000_0140, 32'h0);
    chk("lw_140_miss", {31'b0, freeze}, 32'd1);
    serve(1, 32'h0BAD_F00D, frz);
    chk("lw_140_addr", s_addr, 32'h140);
    chk("lw_140_resp", read_data, 32'h0BAD_F00D);
    step();
    chk("lw_140_hit", read_data, 32'h0BAD_F00D);
    set_acc(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    chk("lw_40_evicted", {31'b0, freeze}, 32'd1);
    serve(1, 32'hCAFE_F00D, frz);
    chk("lw_40_refill", read_data, 32'hCAFE_F00D);
    step();
    chk("lw_40_rehit", {31'b0, freeze}, 32'd0);

    // Reset while a read is outstanding
    set_acc(1'b0, 1'b0, 32'h0000_0140, 32'h0);
    step();
    chk("rd_wait_req", {31'b0, mem_req}, 32'd1);
    rst_b = 1'b0;
    #1;
    chk("midrst_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_freeze", {31'b0, freeze}, 32'd0);
    chk("midrst_read_data", read_data, 32'd0);
    step(); step();
    rst_b = 1'b1;
    set_acc(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    chk("post_rst_miss", {31'b0, freeze}, 32'd1);
    serve(1, 32'h5555_AAAA, frz);
    chk("post_rst_resp", read_data, 32'h5555_AAAA);
    step();

    // Idle cycles with arbitrary address
    cache_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu_result = $urandom;
      mem_write = 1'($urandom_range(0, 1));
      #1;
      chk("idle_freeze", {31'b0, freeze}, 32'd0);
      chk("idle_req", {31'b0, mem_req}, 32'd0);
      chk("idle_read_data", read_data, 32'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
